// File: rtl/lab2_proc_fetch_drop_unit.sv
// lab2_proc_fetch_drop_unit
//   Sits between the processor fetch stage and instruction memory. Tracks how
//   many imem requests are outstanding and, when the control unit squashes the
//   fetch stream (drop), discards every response still owed for requests issued
//   before the squash. Responses pass through combinationally with no storage.
//
// Parameters
//   p_data_nbits   : width of an instruction response payload
//   p_max_inflight : maximum outstanding imem requests (power of two, >= 2)
//
// Ports
//   clk, reset                    : clock, synchronous active-high reset
//   fetch_req_val / fetch_req_rdy : fetch stage request handshake
//   mem_req_val / mem_req_rdy     : request handshake toward imem
//   mem_resp_val / mem_resp_rdy   : response handshake from imem
//   mem_resp_data                 : response payload from imem
//   proc_resp_val / proc_resp_rdy : response handshake toward decode
//   proc_resp_data                : forwarded payload (= mem_resp_data)
//   drop                          : squash pulse on PC redirect
//   inflight                      : current outstanding-request count
//   num_dropped                   : saturating count of discarded responses
module lab2_proc_fetch_drop_unit #(
   parameter int unsigned p_data_nbits   = 32,
   parameter int unsigned p_max_inflight = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              fetch_req_val,
   output logic                              fetch_req_rdy,
   output logic                              mem_req_val,
   input  logic                              mem_req_rdy,
   input  logic                              mem_resp_val,
   output logic                              mem_resp_rdy,
   input  logic [p_data_nbits-1:0]           mem_resp_data,
   output logic                              proc_resp_val,
   input  logic                              proc_resp_rdy,
   output logic [p_data_nbits-1:0]           proc_resp_data,
   input  logic                              drop,
   output logic [$clog2(p_max_inflight):0]   inflight,
   output logic [15:0]                       num_dropped
);

   localparam int unsigned CntW   = $clog2(p_max_inflight) + 1;
   localparam logic [CntW-1:0] MaxCnt = CntW'(p_max_inflight);

   typedef enum logic {StPass, StDrain} state_t;

   state_t          state;
   logic [CntW-1:0] drop_cnt;
   logic [CntW-1:0] drop_cnt_next;
   logic [CntW-1:0] inflight_next;
   logic [CntW-1:0] issue_ext;
   logic [CntW-1:0] fire_ext;
   logic            full;
   logic            nonzero;
   logic            pass_mode;
   logic            issue;
   logic            resp_fire;
   logic            discard;

   always_comb begin
      full      = (inflight == MaxCnt);
      nonzero   = (inflight != '0);
      // A drop cycle already discards, even before the state register catches up.
      pass_mode = (state == StPass) && !drop;

      // Handshakes are forced low during reset so nothing leaks out that cycle.
      mem_req_val   = !reset && fetch_req_val && !full;
      fetch_req_rdy = !reset && mem_req_rdy && !full;
      proc_resp_val = !reset && pass_mode && mem_resp_val && nonzero;
      // Never accept a response nobody asked for (inflight == 0).
      mem_resp_rdy  = !reset && nonzero && (pass_mode ? proc_resp_rdy : 1'b1);

      proc_resp_data = mem_resp_data;

      issue     = mem_req_val && mem_req_rdy;
      resp_fire = mem_resp_val && mem_resp_rdy;
      discard   = resp_fire && !pass_mode;

      issue_ext = {{(CntW-1){1'b0}}, issue};
      fire_ext  = {{(CntW-1){1'b0}}, resp_fire};

      inflight_next = inflight + issue_ext - fire_ext;

      // On drop, everything outstanding before this cycle is doomed; a request
      // issued in the drop cycle itself is not counted and delivers normally.
      drop_cnt_next = drop_cnt;
      if (drop) begin
         drop_cnt_next = inflight - fire_ext;
      end else if (state == StDrain) begin
         drop_cnt_next = drop_cnt - fire_ext;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= StPass;
         inflight    <= '0;
         drop_cnt    <= '0;
         num_dropped <= 16'd0;
      end else begin
         inflight <= inflight_next;
         drop_cnt <= drop_cnt_next;
         state    <= (drop_cnt_next != '0) ? StDrain : StPass;
         if (discard && (num_dropped != 16'hFFFF)) begin
            num_dropped <= num_dropped + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_lab2_proc_fetch_drop_unit.sv
// Bench for lab2_proc_fetch_drop_unit: directed vector table, hand-written
// drop/drain sequences, a saturation run and randomized traffic, all checked
// against a model that keeps one "doomed" flag per outstanding request.
module tb_lab2_proc_fetch_drop_unit;

   localparam int unsigned MAX = 4;
   localparam int unsigned IW  = $clog2(MAX) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_req_val, fetch_req_rdy;
   logic          mem_req_val, mem_req_rdy;
   logic          mem_resp_val, mem_resp_rdy;
   logic [31:0]   mem_resp_data;
   logic          proc_resp_val, proc_resp_rdy;
   logic [31:0]   proc_resp_data;
   logic          drop;
   logic [IW-1:0] inflight;
   logic [15:0]   num_dropped;

   lab2_proc_fetch_drop_unit #(
      .p_data_nbits   (32),
      .p_max_inflight (MAX)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_req_val  (fetch_req_val),
      .fetch_req_rdy  (fetch_req_rdy),
      .mem_req_val    (mem_req_val),
      .mem_req_rdy    (mem_req_rdy),
      .mem_resp_val   (mem_resp_val),
      .mem_resp_rdy   (mem_resp_rdy),
      .mem_resp_data  (mem_resp_data),
      .proc_resp_val  (proc_resp_val),
      .proc_resp_rdy  (proc_resp_rdy),
      .proc_resp_data (proc_resp_data),
      .drop           (drop),
      .inflight       (inflight),
      .num_dropped    (num_dropped)
   );

   always #5 clk = ~clk;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc_no = 0;

   // Model: one entry per outstanding request, oldest first; 1 = will be discarded.
   bit        mq[$];
   bit [15:0] m_nd = 16'd0;

   // Snapshot of combinational outputs taken mid-cycle.
   logic s_frdy, s_mval, s_mrdy, s_pval;

   typedef struct {
      logic          rst, frv, mrr, mrv, prr, drp;
      logic [31:0]   data;
      logic          e_frdy, e_mval, e_mrdy, e_pval;
      logic [IW-1:0] e_infl;
      logic [15:0]   e_nd;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, frv, mrr, mrv, prr, drp,
                               input logic [31:0] data,
                               input logic e_frdy, e_mval, e_mrdy, e_pval,
                               input int e_infl, input int e_nd);
      vec_t v;
      v.rst = rst; v.frv = frv; v.mrr = mrr; v.mrv = mrv; v.prr = prr; v.drp = drp;
      v.data = data;
      v.e_frdy = e_frdy; v.e_mval = e_mval; v.e_mrdy = e_mrdy; v.e_pval = e_pval;
      v.e_infl = IW'(e_infl); v.e_nd = 16'(e_nd);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc_no, act, exp);
      end
   endtask

   // One clock cycle: drive, predict from model, compare mid-cycle, advance model.
   task automatic cyc(input logic rst, frv, mrr, mrv, prr, drp, input logic [31:0] data);
      int n;
      bit doomed, pass, fire, issue;
      logic e_frdy, e_mval, e_mrdy, e_pval;
      reset = rst; fetch_req_val = frv; mem_req_rdy = mrr; mem_resp_val = mrv;
      proc_resp_rdy = prr; drop = drp; mem_resp_data = data;
      n      = mq.size();
      doomed = (n > 0) && mq[0];
      pass   = !drp && !doomed;
      if (rst) begin
         e_frdy = 0; e_mval = 0; e_mrdy = 0; e_pval = 0;
      end else begin
         e_frdy = mrr && (n < MAX);
         e_mval = frv && (n < MAX);
         e_mrdy = (n > 0) && (pass ? prr : 1'b1);
         e_pval = pass && mrv && (n > 0);
      end
      @(negedge clk);
      cyc_no++;
      s_frdy = fetch_req_rdy; s_mval = mem_req_val; s_mrdy = mem_resp_rdy; s_pval = proc_resp_val;
      chk("fetch_req_rdy", 32'(fetch_req_rdy), 32'(e_frdy));
      chk("mem_req_val", 32'(mem_req_val), 32'(e_mval));
      chk("mem_resp_rdy", 32'(mem_resp_rdy), 32'(e_mrdy));
      chk("proc_resp_val", 32'(proc_resp_val), 32'(e_pval));
      chk("proc_resp_data", proc_resp_data, data);
      if (!rst) begin
         chk("inflight", 32'(inflight), 32'(n));
         chk("num_dropped", 32'(num_dropped), 32'(m_nd));
      end
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_nd = 16'd0;
      end else begin
         fire  = mrv && e_mrdy;
         issue = e_mval && mrr;
         if (fire) begin
            if (!pass && m_nd != 16'hFFFF) m_nd = m_nd + 16'd1;
            void'(mq.pop_front());
         end
         if (drp) foreach (mq[i]) mq[i] = 1'b1;
         if (issue) mq.push_back(1'b0);
      end
      #1;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   initial begin
      vec_t v;
      @(posedge clk);
      #1;
      cyc(1, 0, 0, 0, 0, 0, 32'h0);
      cyc(1, 0, 0, 0, 0, 0, 32'h0);

      // rst frv mrr mrv prr drp data  | frdy mval mrdy pval infl nd
      tbl.push_back(mk(1, 1, 1, 1, 1, 0, 32'h0,        0, 0, 0, 0, 0, 0));
      // pass-through of three back-to-back requests
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,        1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,        1, 1, 1, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 1, 0, 32'h0,        1, 1, 1, 0, 2, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h00000013, 1, 0, 1, 1, 3, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h00100093, 1, 0, 1, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h00200113, 1, 0, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 32'h0,        1, 0, 0, 0, 0, 0));
      // spurious response with nothing outstanding is refused
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0));
      // fill to the limit with no responses
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 1, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 2, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        1, 1, 0, 0, 3, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 4, 0));
      tbl.push_back(mk(0, 1, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 4, 0));
      // drain the four
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h11111111, 0, 0, 1, 1, 4, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h22222222, 1, 0, 1, 1, 3, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h33333333, 1, 0, 1, 1, 2, 0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 32'h44444444, 1, 0, 1, 1, 1, 0));

      foreach (tbl[i]) begin
         v = tbl[i];
         cyc(v.rst, v.frv, v.mrr, v.mrv, v.prr, v.drp, v.data);
         chk($sformatf("tbl%0d_frdy", i), 32'(s_frdy), 32'(v.e_frdy));
         chk($sformatf("tbl%0d_mval", i), 32'(s_mval), 32'(v.e_mval));
         chk($sformatf("tbl%0d_mrdy", i), 32'(s_mrdy), 32'(v.e_mrdy));
         chk($sformatf("tbl%0d_pval", i), 32'(s_pval), 32'(v.e_pval));
      end
      chk("tbl_end_inflight", 32'(inflight), 32'd0);

      // Drop with 2 outstanding and a new issue in the same cycle.
      cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 1, 1, 0, 1, 1, 32'h0);
      chk("d34_inflight", 32'(inflight), 32'd3);
      cyc(0, 0, 0, 1, 1, 0, 32'hA0);
      chk("d34_pval1", 32'(s_pval), 32'd0);
      cyc(0, 0, 0, 1, 1, 0, 32'hA1);
      chk("d34_pval2", 32'(s_pval), 32'd0);
      chk("d34_dropped", 32'(num_dropped), 32'd2);
      cyc(0, 0, 0, 1, 1, 0, 32'hA2);
      chk("d34_pval3", 32'(s_pval), 32'd1);
      chk("d34_inflight_end", 32'(inflight), 32'd0);

      // Drop coinciding with a response, inflight = 3.
      repeat (3) cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 1, 32'hB0);
      chk("d35_pval_drop", 32'(s_pval), 32'd0);
      chk("d35_dropped1", 32'(num_dropped), 32'd3);
      cyc(0, 0, 0, 1, 1, 0, 32'hB1);
      cyc(0, 0, 0, 1, 1, 0, 32'hB2);
      chk("d35_pval_last", 32'(s_pval), 32'd0);
      chk("d35_dropped", 32'(num_dropped), 32'd5);
      cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 0, 32'hB3);
      chk("d35_pass_pval", 32'(s_pval), 32'd1);

      // Second drop during drain reloads the count.
      repeat (2) cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 0, 1, 1, 32'h0);
      cyc(0, 0, 0, 1, 1, 0, 32'hC0);
      chk("d36_pval0", 32'(s_pval), 32'd0);
      repeat (2) cyc(0, 1, 1, 0, 1, 0, 32'h0);
      chk("d36_inflight", 32'(inflight), 32'd3);
      cyc(0, 0, 0, 0, 1, 1, 32'h0);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1, 1, 0, 32'hC1 + 32'(i));
         chk($sformatf("d36_pval%0d", i + 1), 32'(s_pval), 32'd0);
      end
      chk("d36_dropped", 32'(num_dropped), 32'd9);
      cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 0, 32'hC9);
      chk("d36_pass_pval", 32'(s_pval), 32'd1);

      // Reset in the middle of a drain.
      repeat (3) cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 0, 1, 1, 32'h0);
      cyc(0, 0, 0, 1, 1, 0, 32'hD0);
      chk("d37_dropped_pre", 32'(num_dropped), 32'd10);
      cyc(1, 0, 0, 0, 1, 0, 32'h0);
      chk("d37_inflight", 32'(inflight), 32'd0);
      chk("d37_dropped", 32'(num_dropped), 32'd0);
      cyc(0, 0, 0, 1, 1, 0, 32'hD1);
      chk("d37_stale_pval", 32'(s_pval), 32'd0);
      chk("d37_stale_mrdy", 32'(s_mrdy), 32'd0);
      cyc(0, 1, 1, 0, 1, 0, 32'h0);
      cyc(0, 0, 0, 1, 1, 0, 32'hD2);
      chk("d37_new_pval", 32'(s_pval), 32'd1);

      // Saturation: drop held high, one issue and one discard per cycle.
      for (int i = 0; i < 65540; i++) cyc(0, 1, 1, 1, 1, 1, 32'(i));
      chk("sat_dropped", 32'(num_dropped), 32'hFFFF);
      cyc(0, 1, 1, 1, 1, 1, 32'h5A5A);
      chk("sat_hold", 32'(num_dropped), 32'hFFFF);
      cyc(1, 0, 0, 0, 0, 0, 32'h0);

      // Randomized traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 2) != 0),
             ($urandom_range(0, 3) != 0),
             ($urandom_range(0, 11) == 0),
             $urandom());
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
